sevenseg_bcd_capture: RTL and testbench

- Display readback block: snoops the multiplexed, active-low 7-segment bus (abcdefg segments plus digit anodes) driven by the clock's display path.
- Reconstructs the 4-bit hex/BCD value of each digit.
- Used for built-in self-test and for bench comparison against the time/alarm registers.
- Qualifies each sample on anode and segment stability, then publishes per-digit values, flags and a frame-complete pulse.

---
 rtl/sevenseg_pkg.sv | 33 +++
 rtl/sevenseg_bcd_capture_decode.sv | 38 +++
 rtl/sevenseg_bcd_capture.sv | 205 ++++++++++++++++++++
 tb/tb_sevenseg_bcd_capture.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment readback block: active-low abcdefg
// patterns, capture FSM states and the stability counter width.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } cap_state_t;

    // Wide enough for the largest legal STABLE_CYCLES (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/sevenseg_bcd_capture_decode.sv
// Combinational active-low abcdefg pattern to hex value decoder, with
// blank (all segments off) and unrecognised-pattern flags.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] value,
    output logic       blank,
    output logic       err
);

    always_comb begin
        value = 4'h0;
        blank = 1'b0;
        err   = 1'b0;
        case (seg_n)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_bcd_capture.sv
// Snoops a multiplexed active-low 7-segment bus and reconstructs per-digit values.
// Optional decimal-point capture is enabled with `define SEVENSEG_CAP_DP_EN.
module sevenseg_bcd_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
`ifdef SEVENSEG_CAP_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_dp,
`endif
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ONE    = NUM_DIGITS'(1);
    localparam logic [CNT_W-1:0]      STABLE = CNT_W'(STABLE_CYCLES);

`ifdef SEVENSEG_CAP_DP_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif

    logic [PW-1:0]         pat_in;
    logic [PW-1:0]         pat_p0;
    logic [PW-1:0]         lat_pat;
    logic [NUM_DIGITS-1:0] an_p0;
    logic [NUM_DIGITS-1:0] lat_an;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] wr_mask;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      lat_idx;
    logic                  onehot;
    logic                  match;
    cap_state_t            state;
    cap_state_t            state_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;
    logic                  relatch;
    logic                  wr;
    logic                  frame_pend;
    logic [3:0]            dec_val;
    logic                  dec_blank;
    logic                  dec_err;

`ifdef SEVENSEG_CAP_DP_EN
    assign pat_in = {dp_n, seg_n};
`else
    assign pat_in = seg_n;
`endif

    // Stage p0: register the bus once; everything downstream uses these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p0  <= '1;
            pat_p0 <= '1;
        end else begin
            an_p0  <= an_n;
            pat_p0 <= pat_in;
        end
    end

    always_comb begin
        sel    = ~an_p0;
        onehot = (sel != '0) && ((sel & (sel - ONE)) == '0);
        idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = IDX_W'(i);
        end
    end

    assign match = (an_p0 == lat_an) && (pat_p0 == lat_pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_an  <= '1;
            lat_pat <= '1;
            lat_idx <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (relatch) begin
                lat_an  <= an_p0;
                lat_pat <= pat_p0;
                lat_idx <= idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        relatch = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE: begin
                if (onehot) begin
                    state_n = SETTLE;
                    cnt_n   = CNT_W'(1);
                    relatch = 1'b1;
                end
            end
            SETTLE: begin
                if (match) begin
                    if (cnt >= STABLE) state_n = CAPTURE;
                    else               cnt_n   = cnt + CNT_W'(1);
                end else if (onehot) begin
                    cnt_n   = CNT_W'(1);
                    relatch = 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            CAPTURE: begin
                wr      = 1'b1;
                state_n = HOLD;
                cnt_n   = '0;
            end
            HOLD: begin
                if (!match) begin
                    if (onehot) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_W'(1);
                        relatch = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // clear wins over a capture in the same cycle and restarts qualification
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            relatch = 1'b0;
            wr      = 1'b0;
        end
    end

    sevenseg_pattern_decode u_decode (
        .seg_n (lat_pat[6:0]),
        .value (dec_val),
        .blank (dec_blank),
        .err   (dec_err)
    );

    assign wr_mask = ONE << lat_idx;

    // Stage p1: per-digit result registers and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            digit_err   <= '0;
            frame_done  <= 1'b0;
            frame_pend  <= 1'b0;
`ifdef SEVENSEG_CAP_DP_EN
            digit_dp    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_pend <= 1'b0;
            if (clear) begin
                digit_valid <= '0;
                digit_blank <= '0;
                digit_err   <= '0;
`ifdef SEVENSEG_CAP_DP_EN
                digit_dp    <= '0;
`endif
            end else if (wr) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (lat_idx == IDX_W'(i)) digits[4*i +: 4] <= dec_val;
                end
                digit_valid <= digit_valid | wr_mask;
                digit_blank <= dec_blank ? (digit_blank | wr_mask) : (digit_blank & ~wr_mask);
                digit_err   <= dec_err   ? (digit_err | wr_mask)   : (digit_err & ~wr_mask);
`ifdef SEVENSEG_CAP_DP_EN
                digit_dp    <= !lat_pat[7] ? (digit_dp | wr_mask) : (digit_dp & ~wr_mask);
`endif
                frame_pend  <= ((digit_valid | wr_mask) == '1);
            end else if (frame_pend) begin
                // Start the next frame with only the just-written digit valid.
                frame_done  <= 1'b1;
                digit_valid <= wr_mask;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_bcd_capture.sv
// Self-checking bench for sevenseg_bcd_capture: decoder table, directed
// scenarios, and randomized segments checked against a table-based model.
module tb_sevenseg_bcd_capture;

    localparam int ND = 4;
    localparam int SC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_blank;
    logic [3:0]  digit_err;
    logic        frame_done;
`ifdef SEVENSEG_CAP_DP_EN
    logic        dp_n;
    logic [3:0]  digit_dp;
`endif

    logic [6:0]  dseg;
    logic [3:0]  dval;
    logic        dblank;
    logic        derr;

    always #5 clk = ~clk;

    sevenseg_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
`ifdef SEVENSEG_CAP_DP_EN
        .dp_n        (dp_n),
        .digit_dp    (digit_dp),
`endif
        .clear       (clear),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .digit_err   (digit_err),
        .frame_done  (frame_done)
    );

    sevenseg_pattern_decode u_dec (
        .seg_n (dseg),
        .value (dval),
        .blank (dblank),
        .err   (derr)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] val;
        logic       blank;
        logic       err;
    } dvec_t;

    logic [6:0] pat_tab [16];
    dvec_t      dv [19];

    int checks = 0;
    int failures = 0;
    int fd_seen = 0;
    int fd_base;

    logic [3:0] m_dig [4];
    logic [3:0] m_valid, m_blank, m_err;
    int         m_frames;

    always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an_n  = a;
        seg_n = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic m_decode(input logic [6:0] s, output logic [3:0] v, output logic b, output logic e);
        v = 4'h0; b = 1'b0; e = 1'b1;
        if (s == 7'b1111111) begin
            b = 1'b1; e = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            if (pat_tab[k] == s) begin
                v = 4'(k); e = 1'b0;
            end
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
        m_valid = '0; m_blank = '0; m_err = '0; m_frames = 0;
        fd_base = fd_seen;
    endtask

    task automatic m_capture(input int d, input logic [6:0] s);
        logic [3:0] v;
        logic b, e;
        m_decode(s, v, b, e);
        m_dig[d] = v;
        m_blank[d] = b;
        m_err[d] = e;
        m_valid[d] = 1'b1;
        if (m_valid == 4'hF) begin
            m_frames++;
            m_valid = '0;
            m_valid[d] = 1'b1;
        end
    endtask

    task automatic check_model(input int n);
        chk($sformatf("rnd%0d_digits", n), digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        chk($sformatf("rnd%0d_valid", n), digit_valid, m_valid);
        chk($sformatf("rnd%0d_blank", n), digit_blank, m_blank);
        chk($sformatf("rnd%0d_err", n), digit_err, m_err);
        chk($sformatf("rnd%0d_frames", n), fd_seen - fd_base, m_frames);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int i = 0; i < 16; i++) dv[i] = '{pat_tab[i], 4'(i), 1'b0, 1'b0};
        dv[16] = '{7'b1111111, 4'h0, 1'b1, 1'b0};
        dv[17] = '{7'b1010101, 4'h0, 1'b0, 1'b1};
        dv[18] = '{7'b0000010, 4'h0, 1'b0, 1'b1};

        rst_n = 1'b0; clear = 1'b0; an_n = 4'hF; seg_n = 7'h7F; dseg = 7'h7F;
`ifdef SEVENSEG_CAP_DP_EN
        dp_n = 1'b1;
`endif

        // Decoder table vectors.
        for (int i = 0; i < 19; i++) begin
            dseg = dv[i].seg;
            #1;
            chk($sformatf("dec%0d_val", i), dval, dv[i].val);
            chk($sformatf("dec%0d_blank", i), dblank, dv[i].blank);
            chk($sformatf("dec%0d_err", i), derr, dv[i].err);
        end

        repeat (3) @(negedge clk);
        chk("reset_digits", digits, 16'h0);
        chk("reset_valid", digit_valid, 4'h0);
        chk("reset_blank", digit_blank, 4'h0);
        chk("reset_err", digit_err, 4'h0);
        chk("reset_frame", frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single digit capture.
        drive(4'b1110, 7'b0000110, 12);
        chk("t1_digit0", digits[3:0], 4'h3);
        chk("t1_valid", digit_valid, 4'b0001);
        chk("t1_err", digit_err, 4'b0000);
        chk("t1_blank", digit_blank, 4'b0000);
        drive(4'hF, 7'h7F, 2);

        // Full frame, back to back.
        pulse_clear();
        fd_base = fd_seen;
        drive(4'b1110, 7'b0100100, 10);
        drive(4'b1101, 7'b0000100, 10);
        drive(4'b1011, 7'b0110001, 10);
        drive(4'b0111, 7'b1001111, 10);
        drive(4'hF, 7'h7F, 4);
        chk("t2_digits", digits, 16'h1C95);
        chk("t2_frame_pulses", fd_seen - fd_base, 1);
        chk("t2_valid", digit_valid, 4'b1000);

        // Unstable pattern never qualifies.
        pulse_clear();
        for (int k = 0; k < 10; k++) drive(4'b1110, (k % 2) ? 7'b0100100 : 7'b0100000, 4);
        drive(4'hF, 7'h7F, 2);
        chk("t3_valid", digit_valid, 4'b0000);
        chk("t3_digits", digits, 16'h1C95);

        // Ghosting guard, then blank capture.
        drive(4'b1100, 7'b0000000, 20);
        chk("t4_multihot_valid", digit_valid, 4'b0000);
        drive(4'b1101, 7'b1111111, 10);
        drive(4'hF, 7'h7F, 2);
        chk("t4_valid", digit_valid, 4'b0010);
        chk("t4_blank", digit_blank, 4'b0010);
        chk("t4_digit1", digits[7:4], 4'h0);

        // Unrecognised pattern, then clear on the capture cycle.
        drive(4'b1011, 7'b1010101, 12);
        drive(4'hF, 7'h7F, 2);
        chk("t5_err", digit_err, 4'b0100);
        chk("t5_digit2", digits[11:8], 4'h0);
        chk("t5_valid", digit_valid, 4'b0110);
        an_n = 4'b0111; seg_n = 7'b0100100;
        for (int c = 0; c < 13; c++) begin
            clear = (c == 10);
            @(negedge clk);
        end
        clear = 1'b0;
        drive(4'hF, 7'h7F, 2);
        chk("t5_clr_valid", digit_valid, 4'b0000);
        chk("t5_clr_err", digit_err, 4'b0000);
        chk("t5_clr_blank", digit_blank, 4'b0000);
        chk("t5_clr_digits", digits, 16'h1005);

        // Reset in the middle of SETTLE.
        drive(4'b1101, 7'b0001111, 4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_digits", digits, 16'h0);
        chk("t6_rst_valid", digit_valid, 4'h0);
        chk("t6_rst_flags", {digit_blank, digit_err}, 8'h0);
        chk("t6_rst_frame", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_early", digit_valid, 4'b0000);
        @(posedge clk);
        #1;
        chk("t6_valid", digit_valid, 4'b0010);
        chk("t6_digits", digits, 16'h0070);
        @(negedge clk);
        drive(4'hF, 7'h7F, 2);

        // Randomized segments separated by idle gaps.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int n = 0; n < 60; n++) begin
            logic [3:0] a;
            logic [6:0] s;
            int len;
            int d;
            if ($urandom_range(0, 9) < 8) a = ~(4'b0001 << $urandom_range(0, 3));
            else                          a = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0:       s = 7'($urandom_range(0, 127));
                1:       s = 7'b1111111;
                default: s = pat_tab[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(1, 14);
            drive(a, s, len);
            drive(4'hF, 7'h7F, 4);
            if ($countones(~a) == 1 && len >= SC + 1) begin
                d = 0;
                for (int k = 0; k < 4; k++) if (!a[k]) d = k;
                m_capture(d, s);
            end
            if ($urandom_range(0, 7) == 0) begin
                pulse_clear();
                m_valid = '0; m_blank = '0; m_err = '0;
            end
            check_model(n);
`ifdef SEVENSEG_CAP_DP_EN
            chk($sformatf("rnd%0d_dp", n), digit_dp, 4'h0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
